// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared state encoding and RV32I funct3 width codes for the LSU.
// Revision    : 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        FIN     = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_avm_if
// Description : Avalon-MM master bundle between the LSU and its memory slave.
// Revision    : 1.0
// ============================================================================
interface lsu_avm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;
    logic                avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );

endinterface : lsu_avm_if
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane
// Description : Combinational byte-lane steering, legality check and load
//               extraction/extension for a 32-bit data bus.
// Revision    : 1.0
// ============================================================================
module lsu_lane
    import lsu_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic        illegal,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] readdata,
    output logic [31:0] ld_data
);

    logic        w_f3_ok;
    logic        w_align_ok;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Unsigned widths are only meaningful for loads.
    always_comb begin
        w_f3_ok    = 1'b0;
        w_align_ok = 1'b1;
        case (funct3)
            F3_B:  w_f3_ok = 1'b1;
            F3_H:  begin w_f3_ok = 1'b1;    w_align_ok = ~addr_lo[0];        end
            F3_W:  begin w_f3_ok = 1'b1;    w_align_ok = (addr_lo == 2'b00); end
            F3_BU: w_f3_ok = is_load;
            F3_HU: begin w_f3_ok = is_load; w_align_ok = ~addr_lo[0];        end
            default: w_f3_ok = 1'b0;
        endcase
        illegal = ~(is_load ^ is_store) | ~w_f3_ok | ~w_align_ok;
    end

    always_comb begin
        byteenable = 4'b1111;
        writedata  = wdata;
        case (funct3[1:0])
            2'b00: begin
                byteenable = 4'b0001 << addr_lo;
                writedata  = {4{wdata[7:0]}};
            end
            2'b01: begin
                byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
                writedata  = {2{wdata[15:0]}};
            end
            default: begin
                byteenable = 4'b1111;
                writedata  = wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = readdata[7:0];
        case (ld_addr_lo)
            2'd0: w_byte = readdata[7:0];
            2'd1: w_byte = readdata[15:8];
            2'd2: w_byte = readdata[23:16];
            2'd3: w_byte = readdata[31:24];
            default: w_byte = readdata[7:0];
        endcase
        w_half = ld_addr_lo[1] ? readdata[31:16] : readdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   ld_data = {24'd0, w_byte};
            F3_H:    ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   ld_data = {16'd0, w_half};
            default: ld_data = readdata;
        endcase
    end

endmodule : lsu_lane
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory stage issuing one Avalon-MM transaction per load/store,
//               with fully registered outputs.
// Revision    : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    lsu_avm_if.master         avm
);

    lsu_state_t        r_state, w_state_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic [31:0]       r_rdata, w_rdata_nxt;
    logic [ADDR_W-1:0] r_address, w_address_nxt;
    logic              r_read, w_read_nxt;
    logic              r_write, w_write_nxt;
    logic [31:0]       r_writedata, w_writedata_nxt;
    logic [3:0]        r_byteenable, w_byteenable_nxt;
    logic [2:0]        r_ld_f3, w_ld_f3_nxt;
    logic [1:0]        r_ld_lo, w_ld_lo_nxt;

    logic              w_illegal;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
    logic [31:0]       w_ld_data;

    lsu_lane u_lane (
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .illegal    (w_illegal),
        .byteenable (w_be),
        .writedata  (w_wd),
        .ld_funct3  (r_ld_f3),
        .ld_addr_lo (r_ld_lo),
        .readdata   (avm.avm_readdata),
        .ld_data    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_ld_f3      <= '0;
            r_ld_lo      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_rdata      <= w_rdata_nxt;
            r_address    <= w_address_nxt;
            r_read       <= w_read_nxt;
            r_write      <= w_write_nxt;
            r_writedata  <= w_writedata_nxt;
            r_byteenable <= w_byteenable_nxt;
            r_ld_f3      <= w_ld_f3_nxt;
            r_ld_lo      <= w_ld_lo_nxt;
        end
    end

    // Every output is computed one cycle ahead so it leaves a flop.
    always_comb begin
        w_state_nxt      = r_state;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_err_nxt        = 1'b0;
        w_rdata_nxt      = r_rdata;
        w_address_nxt    = r_address;
        w_read_nxt       = r_read;
        w_write_nxt      = r_write;
        w_writedata_nxt  = r_writedata;
        w_byteenable_nxt = r_byteenable;
        w_ld_f3_nxt      = r_ld_f3;
        w_ld_lo_nxt      = r_ld_lo;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_ld_f3_nxt = funct3;
                    w_ld_lo_nxt = addr[1:0];
                    if (w_illegal) begin
                        w_state_nxt = FIN;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_busy_nxt       = 1'b1;
                        w_address_nxt    = {addr[ADDR_W-1:2], 2'b00};
                        w_byteenable_nxt = w_be;
                        if (is_load) begin
                            w_state_nxt = RD_REQ;
                            w_read_nxt  = 1'b1;
                        end else begin
                            w_state_nxt     = WR_REQ;
                            w_write_nxt     = 1'b1;
                            w_writedata_nxt = w_wd;
                        end
                    end
                end
            end
            RD_REQ: begin
                if (!avm.avm_waitrequest) begin
                    w_state_nxt = RD_WAIT;
                    w_read_nxt  = 1'b0;
                end
            end
            RD_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    w_state_nxt = FIN;
                    w_rdata_nxt = w_ld_data;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            WR_REQ: begin
                if (!avm.avm_waitrequest) begin
                    w_state_nxt = FIN;
                    w_write_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
            end
        endcase
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign err                = r_err;
    assign rdata              = r_rdata;
    assign avm.avm_address    = r_address;
    assign avm.avm_read       = r_read;
    assign avm.avm_write      = r_write;
    assign avm.avm_writedata  = r_writedata;
    assign avm.avm_byteenable = r_byteenable;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_avm_if #(.ADDR_W(32), .DATA_W(32)) avm ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .is_load  (is_load),
        .is_store (is_store),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .avm      (avm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and plays a slave with a given number of wait states.
    task automatic xact(
        input  logic        ld,
        input  logic        st,
        input  logic [2:0]  f3,
        input  logic [31:0] a,
        input  logic [31:0] wdv,
        input  int          waits,
        input  logic [31:0] rd,
        input  logic        hold,
        output int          done_cyc,
        output int          n_rd,
        output int          n_wr,
        output logic        err_o,
        output logic [31:0] cmd_addr,
        output logic [3:0]  cmd_be,
        output logic [31:0] cmd_wd,
        output int          n_extra
    );
        int   wcnt;
        logic acc;
        wcnt = 0; acc = 1'b0; done_cyc = -1; n_rd = 0; n_wr = 0; err_o = 1'b0;
        cmd_addr = '0; cmd_be = '0; cmd_wd = '0; n_extra = 0;
        req = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wdv;
        for (int cyc = 1; cyc <= 30 && done_cyc < 0; cyc++) begin
            step();
            if (!hold) req = 1'b0;
            avm.avm_readdatavalid = 1'b0;
            if (acc) begin
                avm.avm_readdatavalid = 1'b1;
                avm.avm_readdata      = rd;
                acc = 1'b0;
            end
            if ((avm.avm_read || avm.avm_write) && (n_rd + n_wr == 0)) begin
                cmd_addr = avm.avm_address;
                cmd_be   = avm.avm_byteenable;
                cmd_wd   = avm.avm_writedata;
            end
            if (avm.avm_read)  n_rd++;
            if (avm.avm_write) n_wr++;
            if (done) begin
                done_cyc = cyc;
                err_o    = err;
                req      = 1'b0;
            end
            avm.avm_waitrequest = 1'b0;
            if (avm.avm_read || avm.avm_write) begin
                if (wcnt < waits) begin
                    avm.avm_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    acc = avm.avm_read;
                end
            end
        end
        req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            avm.avm_readdatavalid = 1'b0;
            if (done) n_extra++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc, nr, nw, nx, dn;
        logic        e;
        logic [31:0] ca, cw;
        logic [3:0]  cb;

        reset = 1'b1; req = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'd0; addr = '0; wdata = '0;
        avm.avm_readdata = '0; avm.avm_readdatavalid = 1'b0; avm.avm_waitrequest = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdwr", {30'd0, avm.avm_read, avm.avm_write}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", avm.avm_address, 32'd0);
        check("rst_be_wd", avm.avm_writedata | {28'd0, avm.avm_byteenable}, 32'd0);

        // SB to the top lane
        xact(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'd0, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("sb_done_cyc", dc, 2);
        check("sb_err", {31'd0, e}, 32'd0);
        check("sb_addr", ca, 32'h0000_1000);
        check("sb_be", {28'd0, cb}, 32'h8);
        check("sb_wd", cw, 32'hA5A5_A5A5);
        check("sb_wr_cycles", nw, 1);
        check("sb_extra_done", nx, 0);

        // LB with two wait states
        xact(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'd0, 2, 32'h0000_8000, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("lb_rd_cycles", nr, 3);
        check("lb_done_cyc", dc, 5);
        check("lb_be", {28'd0, cb}, 32'h2);
        check("lb_addr", ca, 32'h0000_2000);
        check("lb_rdata", rdata, 32'hFFFF_FF80);

        xact(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'd0, 0, 32'h0000_8000, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("lbu_done_cyc", dc, 3);
        check("lbu_rdata", rdata, 32'h0000_0080);

        xact(1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'd0, 0, 32'h8001_1234, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("lh_be", {28'd0, cb}, 32'hC);
        check("lh_rdata", rdata, 32'hFFFF_8001);

        // Misaligned LW: immediate error, no bus, rdata untouched
        xact(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 0, 32'h1111_1111, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("lw_mis_done_cyc", dc, 1);
        check("lw_mis_err", {31'd0, e}, 32'd1);
        check("lw_mis_bus", nr + nw, 0);
        check("lw_mis_rdata", rdata, 32'hFFFF_8001);

        xact(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'd0, 0, 32'd0, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("both_err", {31'd0, e}, 32'd1);
        check("both_bus", nr + nw, 0);

        xact(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h1234_5678, 0, 32'd0, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("sbu_err", {31'd0, e}, 32'd1);
        check("sbu_bus", nr + nw, 0);

        xact(1'b0, 1'b0, 3'b010, 32'h0000_0000, 32'd0, 0, 32'd0, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("none_err", {31'd0, e}, 32'd1);
        check("none_done_cyc", dc, 1);

        xact(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 0, 32'd0, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("sh_addr", ca, 32'h0000_0010);
        check("sh_be", {28'd0, cb}, 32'hC);
        check("sh_wd", cw, 32'hABCD_ABCD);
        check("sh_rdata_kept", rdata, 32'hFFFF_8001);

        xact(1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'd0, 0, 32'h8001_1234, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("lhu_rdata", rdata, 32'h0000_8001);

        xact(1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'h1122_3344, 0, 32'd0, 1'b0,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("sw_be", {28'd0, cb}, 32'hF);
        check("sw_wd", cw, 32'h1122_3344);

        // req held high throughout: one done only
        xact(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'd0, 1, 32'hCAFE_F00D, 1'b1,
             dc, nr, nw, e, ca, cb, cw, nx);
        check("hold_done_cyc", dc, 4);
        check("hold_rd_cycles", nr, 2);
        check("hold_extra_done", nx, 0);
        check("hold_rdata", rdata, 32'hCAFE_F00D);

        // Reset while waiting for read data
        req = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_4000;
        avm.avm_waitrequest = 1'b0;
        step();
        req = 1'b0;
        step();
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        avm.avm_readdatavalid = 1'b1;
        avm.avm_readdata = 32'hDEAD_BEEF;
        check("mid_read", {31'd0, avm.avm_read}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        dn = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            avm.avm_readdatavalid = 1'b0;
            if (done) dn++;
        end
        check("mid_no_done", dn, 0);
        check("mid_rdata", rdata, 32'd0);
        check("mid_busy_post", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_load_store_unit
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address and the rs2 value as store data. It runs one Avalon-MM master transaction per load or store, handling byte lanes, byte-enables and load sign/zero extension. The core holds its pipeline on busy and captures rdata when done pulses.

Parameters:
ADDR_W, 32, width of the byte address from the ALU and of avm_address.
DATA_W, 32, bus and register data width; only 32 is supported.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  1  request strobe; sampled only in IDLE
is_load  in  1  request is a load
is_store  in  1  request is a store
funct3  in  3  RV32I width/sign field
addr  in  ADDR_W  effective byte address (ALU sol)
wdata  in  32  store data (rs2)
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with done for a rejected request
rdata  out  32  extended load result; held until the next load completes
avm_address  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  32  lane-replicated store data
avm_byteenable  out  4  lane enables
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data qualifier
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset: state IDLE. busy, done, err, avm_read and avm_write are 0. rdata, avm_address, avm_writedata and avm_byteenable are 0.
- All outputs are registered.
- States:
  - IDLE: waits for a request.
  - RD_REQ: read command is presented on the bus.
  - RD_WAIT: waiting for read data.
  - WR_REQ: write command is presented on the bus.
  - FIN: completion cycle.
- Acceptance: in IDLE, req=1 latches addr, wdata, funct3 and the operation type. req is ignored in every other state.
- Rejected requests go IDLE->FIN with err=1 and no bus activity. A request is rejected when any of these holds:
  - is_load and is_store are both set;
  - neither is_load nor is_store is set;
  - funct3 is illegal (loads accept 000/001/010/100/101; stores accept 000/001/010);
  - the access is misaligned (halfword with addr[0]=1, word with addr[1:0]!=0).
- Loads:
  - IDLE->RD_REQ: avm_read=1 with address and byteenable.
  - Command phase: avm_read and avm_address stay stable while avm_waitrequest=1. When avm_waitrequest=0, go to RD_WAIT and deassert avm_read.
  - RD_WAIT: on avm_readdatavalid=1, register the extracted, extended lane into rdata and go to FIN.
  - readdatavalid in the same cycle as the command accept is not supported: the slave has a read latency of at least 1.
- Stores: IDLE->WR_REQ with avm_write=1. Hold until avm_waitrequest=0, then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. A new req is accepted only in the cycle after FIN.
- Minimum latency, with the request accepted at cycle 0 and no wait states:
  - store: done at cycle 2;
  - load: done at cycle 3, given readdatavalid at cycle 2.
- Byte lanes (b = addr[1:0]):
  - SB: byteenable = 4'b0001 << b; writedata = {4{wdata[7:0]}}.
  - SH: byteenable = addr[1] ? 4'b1100 : 4'b0011; writedata = {2{wdata[15:0]}}.
  - SW: byteenable = 4'b1111; writedata = wdata.
  - Loads drive the same byteenable pattern as the matching store width.
- Load extension:
  - LB: byte at lane b, sign-extended.
  - LBU: byte at lane b, zero-extended.
  - LH / LHU: halfword at lane addr[1], sign- / zero-extended.
  - LW: full word.
- rdata changes only on a successful load. Stores and errors do not touch it.
- Reset mid-operation: next edge returns to IDLE with read and write deasserted. A readdatavalid arriving afterwards is ignored.
- Address wrap: no increment is performed, so none applies.

Decomposition:
- Shared package lsu_pkg: state enum lsu_state_t {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN}; funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- One combinational sub-module lsu_lane, containing:
  - byteenable and writedata generation;
  - alignment and legality check;
  - load extraction and extension.
- FSM and registers stay in load_store_unit.

Test Plan:
- SB, addr=0x1003, wdata=0xA5, no wait states -> avm_address=0x1000, byteenable=4'b1000, writedata=0xA5A5A5A5, avm_write for 1 cycle, done at cycle 2, err=0.
- LB, addr=0x2001, readdata=0x0000_8000 after 2 waitrequest cycles -> avm_read held 3 cycles, rdata=0xFFFFFF80. LBU from the same address and data -> rdata=0x00000080.
- LH, addr=0x3002, readdata=0x8001_1234 -> rdata=0xFFFF8001. LW, addr=0x3001 -> done and err at cycle 1, no avm_read, rdata unchanged.
- is_load=is_store=1, or store funct3=3'b100 -> err pulse, no bus activity. A req asserted while busy -> ignored, exactly one done per accepted request.
- reset asserted in RD_WAIT, readdatavalid one cycle later -> avm_read=0, busy=0, done never pulses, rdata=0.
